// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Imported by the arbiter top level and the pending-load scoreboard.
package regfile_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LD
    } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-load busy bits with set-priority update and two
// combinational query ports for load-use hazard detection.
module reg_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_reg,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic [ADDR_W-1:0] query1,
    input  logic [ADDR_W-1:0] query2,
    output logic              hit1,
    output logic              hit2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                // $zero can never hold a pending load
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_valid && (set_reg == ADDR_W'(gi));
                assign clr_hit = clr_valid && (clr_reg == ADDR_W'(gi));
                // A new issue outranks a returning load to the same register
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign hit1 = busy_reg[query1];
    assign hit2 = busy_reg[query2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between ALU writeback (priority)
// and load returns (starvation-protected); tracks pending loads for decode.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              LdValid,
    input  logic [ADDR_W-1:0] LdReg,
    input  logic [DATA_W-1:0] LdData,
    output logic              LdReady,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic [ADDR_W-1:0] QueryReg1,
    input  logic [ADDR_W-1:0] QueryReg2,
    output logic              Hazard,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    grant_e             grant;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;

    logic               write_en_reg;
    logic               write_en_next;
    logic [ADDR_W-1:0]  write_reg_reg;
    logic [DATA_W-1:0]  write_data_reg;

    logic               hit1;
    logic               hit2;

    always_comb begin
        grant    = GNT_NONE;
        sel_reg  = '0;
        sel_data = '0;
        if (LdValid && (!AluValid || starve_cnt_reg == STARVE_MAX)) begin
            grant    = GNT_LD;
            sel_reg  = LdReg;
            sel_data = LdData;
        end else if (AluValid) begin
            grant    = GNT_ALU;
            sel_reg  = AluReg;
            sel_data = AluData;
        end
    end

    assign AluReady = (grant == GNT_ALU);
    assign LdReady  = (grant == GNT_LD);

    always_comb begin
        starve_cnt_next = '0;
        if (LdValid && !LdReady) begin
            starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? starve_cnt_reg
                                                             : starve_cnt_reg + 1'b1;
        end
    end

    // Writes aimed at $zero are still accepted, just never reach the file
    assign write_en_next = (grant != GNT_NONE) && (sel_reg != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= '0;
            write_en_reg   <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            write_en_reg   <= write_en_next;
            if (grant != GNT_NONE) begin
                write_reg_reg  <= sel_reg;
                write_data_reg <= sel_data;
            end
        end
    end

    assign RegWrite      = write_en_reg;
    assign WriteRegister = write_reg_reg;
    assign WriteData     = write_data_reg;

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_valid(IssueValid),
        .set_reg  (IssueReg),
        .clr_valid(LdReady),
        .clr_reg  (LdReg),
        .query1   (QueryReg1),
        .query2   (QueryReg2),
        .hit1     (hit1),
        .hit2     (hit2)
    );

    assign Hazard = hit1 | hit2;

endmodule
